// File: rtl/uart_pkg.sv
// Shared UART types: stop-bit and parity encodings plus the transmitter FSM
// states, with helpers that map raw configuration port values onto them.
package uart_pkg;

  typedef enum logic [1:0] {
    SB_ONE  = 2'd0,
    SB_ONE5 = 2'd1,
    SB_TWO  = 2'd2
  } uart_stopbits_t;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_ODD   = 3'd1,
    PAR_EVEN  = 3'd2,
    PAR_SPACE = 3'd3,
    PAR_MARK  = 3'd4
  } uart_parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // Raw value 3 has no meaning on the line and falls back to one stop bit.
  function automatic uart_stopbits_t decode_stopbits(input logic [1:0] raw);
    uart_stopbits_t sb;
    case (raw)
      2'd1:    sb = SB_ONE5;
      2'd2:    sb = SB_TWO;
      default: sb = SB_ONE;
    endcase
    return sb;
  endfunction

  // Raw values 5..7 are unused encodings and behave as "no parity".
  function automatic uart_parity_t decode_parity(input logic [2:0] raw);
    uart_parity_t p;
    case (raw)
      3'd1:    p = PAR_ODD;
      3'd2:    p = PAR_EVEN;
      3'd3:    p = PAR_SPACE;
      3'd4:    p = PAR_MARK;
      default: p = PAR_NONE;
    endcase
    return p;
  endfunction

  // data_xor is the XOR of all data bits. Odd parity makes the total count of
  // ones (data + parity) odd, which is what the receiver checks against.
  function automatic logic parity_bit(input uart_parity_t p, input logic data_xor);
    logic b;
    case (p)
      PAR_ODD:  b = ~data_xor;
      PAR_EVEN: b = data_xor;
      PAR_MARK: b = 1'b1;
      default:  b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Word/config handshake between a producer (master) and the UART transmitter
// (slave). Valid/ready: the master holds word, paritytype and stopbitnum
// stable while word_valid is high; a transfer happens on the rising clock
// edge where word_valid and word_ready are both high. word_ready may be high
// without word_valid; word_valid seen while word_ready is low is ignored.
interface uart_transmitter_if #(
  parameter int word_width = 8
);
  logic [word_width-1:0] word;
  logic                  word_valid;
  logic                  word_ready;
  logic [2:0]            paritytype;
  logic [1:0]            stopbitnum;

  modport master (
    output word, word_valid, paritytype, stopbitnum,
    input  word_ready
  );

  modport slave (
    input  word, word_valid, paritytype, stopbitnum,
    output word_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: a free-running up-counter of 2**width cycles. full_tick
// marks the last cycle of a bit period, half_tick the last cycle of the first
// half period. Shared between the UART transmitter and receiver.
module uart_bit_timer #(
  parameter int width = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic full_tick,
  output logic half_tick
);

  localparam logic [width-1:0] HALF_LAST = width'((1 << (width - 1)) - 1);

  logic [width-1:0] timer_q;
  logic [width-1:0] timer_d;

  // Next count: clear wins, otherwise advance (and wrap) while enabled.
  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign full_tick = enable & (timer_q == '1);
  assign half_tick = enable & (timer_q == HALF_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts one word per handshake and serialises it as
// start bit, data LSB first, optional parity bit and 1/1.5/2 stop bits.
// TX is registered from the current state, so the line trails the FSM by one
// clock: TX falls the edge after the transfer, and the cycle the FSM spends
// back in IDLE before the next transfer is the guaranteed idle-high gap.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int word_width     = 8,
  parameter int reductor_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_transmitter_if.slave     tx_if,
  output logic [2:0]            transmitter_state,
  output logic                  TX
);

  localparam int CNT_W = (word_width > 1) ? $clog2(word_width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(word_width - 1);

  uart_tx_state_t        state_q, state_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  uart_parity_t          parity_q, parity_d;
  uart_stopbits_t        stop_q, stop_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;

  logic transfer;
  logic full_tick;
  logic half_tick;

  assign tx_if.word_ready = (state_q == ST_IDLE) & ~reset;
  assign transfer         = tx_if.word_valid & tx_if.word_ready;

  uart_bit_timer #(
    .width(reductor_width)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (transfer),
    .enable   (state_q != ST_IDLE),
    .full_tick(full_tick),
    .half_tick(half_tick)
  );

  // Next-state, frame datapath and line level for the current state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    stop_d    = stop_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (transfer) begin
          state_d   = ST_START;
          shift_d   = tx_if.word;
          bit_cnt_d = '0;
          parity_d  = decode_parity(tx_if.paritytype);
          stop_d    = decode_stopbits(tx_if.stopbitnum);
          par_bit_d = parity_bit(decode_parity(tx_if.paritytype), ^tx_if.word);
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (full_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (full_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (parity_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_bit_q;
        if (full_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        // bit_cnt counts completed stop periods; the half stop bit ends at
        // the half tick of the second period.
        case (stop_q)
          SB_TWO: begin
            if (full_tick) begin
              if (bit_cnt_q != '0) begin
                state_d = ST_IDLE;
              end else begin
                bit_cnt_d = CNT_W'(1);
              end
            end
          end
          SB_ONE5: begin
            if (bit_cnt_q == '0) begin
              if (full_tick) begin
                bit_cnt_d = CNT_W'(1);
              end
            end else if (half_tick) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            if (full_tick) begin
              state_d = ST_IDLE;
            end
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= PAR_NONE;
      stop_q    <= SB_ONE;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      stop_q    <= stop_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

  assign TX                = tx_q;
  assign transmitter_state = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter (word_width=8, T=16): reset values,
// per-cycle TX waveform against a bench-built frame model, parity and stop
// variants, back-to-back frames and reset mid-frame.
module tb_uart_transmitter;

  localparam int W = 8;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] transmitter_state;
  logic       tx;

  int total = 0;
  int bad   = 0;

  logic exp_q[$];

  uart_transmitter_if #(.word_width(W)) tx_if ();

  uart_transmitter #(
    .word_width    (W),
    .reductor_width(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tx_if            (tx_if.slave),
    .transmitter_state(transmitter_state),
    .TX               (tx)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected TX level for every clock of the frame, built from the line format.
  task automatic build_frame(input logic [W-1:0] w, input logic [2:0] par, input logic [1:0] sb);
    logic pb;
    logic has_par;
    int   stop_len;
    exp_q.delete();
    repeat (T) exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      repeat (T) exp_q.push_back(w[i]);
    end
    has_par = 1'b1;
    case (par)
      3'd1:    pb = ~^w;
      3'd2:    pb = ^w;
      3'd3:    pb = 1'b0;
      3'd4:    pb = 1'b1;
      default: begin pb = 1'b0; has_par = 1'b0; end
    endcase
    if (has_par) begin
      repeat (T) exp_q.push_back(pb);
    end
    case (sb)
      2'd1:    stop_len = T + T / 2;
      2'd2:    stop_len = 2 * T;
      default: stop_len = T;
    endcase
    repeat (stop_len) exp_q.push_back(1'b1);
  endtask

  // Driver: wait (bounded) for ready at a falling edge, then present a word.
  task automatic start_frame(input logic [W-1:0] w, input logic [2:0] par, input logic [1:0] sb);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_if.word_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("ready_timeout", 32'd0, 32'd1);
    tx_if.word       = w;
    tx_if.paritytype = par;
    tx_if.stopbitnum = sb;
    tx_if.word_valid = 1'b1;
  endtask

  // Follows a frame whose transfer edge is the next rising edge. Inputs are
  // replaced by the nxt_* values right after transfer. abort_at > 0 stops
  // checking after that many frame cycles.
  task automatic check_frame(input logic [W-1:0] w, input logic [2:0] par, input logic [1:0] sb,
                             input int abort_at, input logic nxt_valid, input logic [W-1:0] nxt_w,
                             input logic [2:0] nxt_par, input logic [1:0] nxt_sb);
    int len;
    int last;
    build_frame(w, par, sb);
    len  = exp_q.size();
    last = (abort_at > 0) ? abort_at : len;
    @(negedge clk);
    check_eq($sformatf("accept_%02h", w), {31'd0, tx_if.word_ready}, 32'd0);
    check_eq($sformatf("gap_%02h", w), {31'd0, tx}, 32'd1);
    tx_if.word       = nxt_w;
    tx_if.paritytype = nxt_par;
    tx_if.stopbitnum = nxt_sb;
    tx_if.word_valid = nxt_valid;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check_eq($sformatf("tx_%02h_p%0d_s%0d_k%0d", w, par, sb, k), {31'd0, tx}, {31'd0, exp_q[k-1]});
      if (k == len - 1) check_eq($sformatf("busy_end_%02h", w), {31'd0, tx_if.word_ready}, 32'd0);
      if (k == len) begin
        check_eq($sformatf("ready_end_%02h_len%0d", w, len), {31'd0, tx_if.word_ready}, 32'd1);
        check_eq($sformatf("idle_state_%02h", w), {29'd0, transmitter_state}, 32'd0);
      end
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic [2:0] par, input logic [1:0] sb);
    logic [2:0] other_par;
    other_par = (par == 3'd4) ? 3'd1 : 3'd4;
    start_frame(w, par, sb);
    check_frame(w, par, sb, 0, 1'b0, ~w, other_par, 2'd2);
  endtask

  initial begin
    reset            = 1'b1;
    tx_if.word       = '0;
    tx_if.word_valid = 1'b0;
    tx_if.paritytype = 3'd0;
    tx_if.stopbitnum = 2'd0;

    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_tx", {31'd0, tx}, 32'd1);
      check_eq("rst_ready", {31'd0, tx_if.word_ready}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, tx_if.word_ready}, 32'd1);
    check_eq("post_rst_state", {29'd0, transmitter_state}, 32'd0);
    check_eq("post_rst_tx", {31'd0, tx}, 32'd1);

    // 8N1 and every parity flavour on A5 (even number of ones).
    send(8'hA5, 3'd0, 2'd0);
    send(8'hA5, 3'd2, 2'd0);
    send(8'hA5, 3'd1, 2'd0);
    send(8'hA5, 3'd4, 2'd0);
    send(8'hA5, 3'd3, 2'd0);
    send(8'hA5, 3'd5, 2'd0);
    // Odd number of ones: odd parity bit 0, even parity bit 1.
    send(8'h07, 3'd1, 2'd0);
    send(8'h07, 3'd2, 2'd0);

    // Stop bit lengths.
    send(8'h00, 3'd0, 2'd0);
    send(8'h00, 3'd0, 2'd1);
    send(8'h00, 3'd0, 2'd2);
    send(8'h00, 3'd0, 2'd3);
    send(8'h5A, 3'd1, 2'd1);

    // Back-to-back: valid stays high through the first frame with 8'h80
    // already presented; it must not disturb frame one and must start next.
    start_frame(8'h01, 3'd0, 2'd0);
    check_frame(8'h01, 3'd0, 2'd0, 0, 1'b1, 8'h80, 3'd0, 2'd0);
    check_frame(8'h80, 3'd0, 2'd0, 0, 1'b0, 8'h11, 3'd2, 2'd1);

    // Reset in the middle of data bit 3.
    start_frame(8'hA5, 3'd0, 2'd0);
    check_frame(8'hA5, 3'd0, 2'd0, T + 3 * T + T / 2, 1'b0, 8'h00, 3'd0, 2'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_tx", {31'd0, tx}, 32'd1);
    check_eq("midrst_ready", {31'd0, tx_if.word_ready}, 32'd0);
    check_eq("midrst_state", {29'd0, transmitter_state}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 2 * T; i++) begin
      @(negedge clk);
      check_eq($sformatf("midrst_idle_tx_%0d", i), {31'd0, tx}, 32'd1);
      check_eq($sformatf("midrst_idle_rdy_%0d", i), {31'd0, tx_if.word_ready}, 32'd1);
    end
    send(8'h3C, 3'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
